// File: rtl/trapez_shaper_mc.sv
// trapez_shaper_mc: multi-channel trapezoidal pulse shaper (delay lines, recursive accumulator, norm shift, saturation).
// Latency: out_valid exactly 2 cycles after each in_valid cycle.
// Backpressure: none; every accepted sample produces exactly one output.
//
// Ports: clk / reset_n (async, active-low); in_valid + in_data (CHANNEL_SIZE packed unsigned samples);
//        cfg_load + cfg_k/cfg_l/cfg_norm -> cfg_error (one-cycle reject pulse);
//        out_valid + out_data (CHANNEL_SIZE packed signed results); settled (delay lines fully primed).
module trapez_shaper_mc #(
  parameter int CHANNEL_SIZE          = 2,
  parameter int SIZE_ADC_DATA         = 14,
  parameter int SIZE_SHAPER_DATA      = 16,
  parameter int SIZE_SHAPER_SHIFT_REG = 300,
  parameter int K_DEFAULT             = 25,
  parameter int L_DEFAULT             = 20,
  parameter int NORM_DEFAULT          = 10
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic                                       in_valid,
  input  logic [CHANNEL_SIZE*SIZE_ADC_DATA-1:0]      in_data,
  input  logic                                       cfg_load,
  input  logic [8:0]                                 cfg_k,
  input  logic [8:0]                                 cfg_l,
  input  logic [4:0]                                 cfg_norm,
  output logic                                       cfg_error,
  output logic                                       out_valid,
  output logic [CHANNEL_SIZE*SIZE_SHAPER_DATA-1:0]   out_data,
  output logic                                       settled
);

  localparam int MAX_D = SIZE_SHAPER_SHIFT_REG;
  localparam int DEPTH = MAX_D + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int ACC_W = SIZE_ADC_DATA + $clog2(MAX_D) + 2;
  localparam int ZP    = ACC_W - SIZE_ADC_DATA;
  // Delay/fill width: 2*511 + 511 is the largest expressible 2k+l.
  localparam int DW    = 11;
  localparam int AW    = ((PW > DW) ? PW : DW) + 1;

  localparam logic FILL = 1'b0;
  localparam logic RUN  = 1'b1;

  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((64'sd1 <<< (SIZE_SHAPER_DATA-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-(64'sd1 <<< (SIZE_SHAPER_DATA-1)));

  logic [8:0]    k_q, k_d, l_q, l_d;
  logic [4:0]    norm_q, norm_d;
  logic          state_q, state_d;
  logic [DW-1:0] fill_q, fill_d, fill_eff;
  logic [PW-1:0] wr_q, wr_d, wa;
  logic          vld1_q, out_valid_q, cfg_error_q;
  logic [DW-1:0] len_req, len_cur, len_nxt;
  logic [DW-1:0] dk, dkl;
  logic [PW-1:0] a1, a2, a3;
  logic          m1, m2, m3;
  logic          cfg_ok;

  function automatic logic [PW-1:0] tap_addr(input logic [PW-1:0] wp, input logic [DW-1:0] dly);
    logic [AW-1:0] a;
    a = AW'(wp) + AW'(DEPTH) - AW'(dly);
    if (a >= AW'(DEPTH)) a = a - AW'(DEPTH);
    return a[PW-1:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] zext(input logic [SIZE_ADC_DATA-1:0] v);
    return signed'({{ZP{1'b0}}, v});
  endfunction

  assign len_req = {1'b0, cfg_k, 1'b0} + {2'b0, cfg_l};
  assign len_cur = {1'b0, k_q, 1'b0} + {2'b0, l_q};
  assign cfg_ok  = cfg_load && (cfg_k != 9'd0) && (len_req <= DW'(MAX_D)) && (cfg_norm <= 5'd24);

  // An accepted load restarts history, so a same-cycle sample sees an empty line at slot 0.
  assign fill_eff = cfg_ok ? '0 : fill_q;
  assign wa       = cfg_ok ? '0 : wr_q;

  assign dk  = {2'b0, k_q};
  assign dkl = {2'b0, k_q} + {2'b0, l_q};
  assign a1  = tap_addr(wa, dk);
  assign a2  = tap_addr(wa, dkl);
  assign a3  = tap_addr(wa, len_cur);
  // Taps older than the samples written since the last flush read as zero.
  assign m1  = (fill_eff >= dk);
  assign m2  = (fill_eff >= dkl);
  assign m3  = (fill_eff >= len_cur);

  always_comb begin
    k_d     = k_q;
    l_d     = l_q;
    norm_d  = norm_q;
    fill_d  = fill_q;
    wr_d    = wr_q;
    len_nxt = len_cur;
    if (cfg_ok) begin
      k_d     = cfg_k;
      l_d     = cfg_l;
      norm_d  = cfg_norm;
      len_nxt = len_req;
      fill_d  = '0;
      wr_d    = '0;
    end
    if (in_valid) begin
      wr_d = (wa == PW'(MAX_D)) ? '0 : wa + 1'b1;
      if (fill_eff < len_nxt) fill_d = fill_eff + 1'b1;
    end
    state_d = (fill_d >= len_nxt) ? RUN : FILL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q         <= 9'(K_DEFAULT);
      l_q         <= 9'(L_DEFAULT);
      norm_q      <= 5'(NORM_DEFAULT);
      state_q     <= FILL;
      fill_q      <= '0;
      wr_q        <= '0;
      vld1_q      <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_error_q <= 1'b0;
    end else begin
      k_q         <= k_d;
      l_q         <= l_d;
      norm_q      <= norm_d;
      state_q     <= state_d;
      fill_q      <= fill_d;
      wr_q        <= wr_d;
      vld1_q      <= in_valid;
      out_valid_q <= vld1_q;
      cfg_error_q <= cfg_load & ~cfg_ok;
    end
  end

  assign out_valid = out_valid_q;
  assign cfg_error = cfg_error_q;
  assign settled   = (state_q == RUN);

  for (genvar c = 0; c < CHANNEL_SIZE; c++) begin : g_ch
    logic [SIZE_ADC_DATA-1:0]    mem_q [DEPTH];
    logic [SIZE_ADC_DATA-1:0]    x, t1, t2, t3;
    logic signed [ACC_W-1:0]     d_c, d_q, s_q, s_sum, y_sh;
    logic [SIZE_SHAPER_DATA-1:0] y_d, y_q;

    assign x  = in_data[c*SIZE_ADC_DATA +: SIZE_ADC_DATA];
    assign t1 = m1 ? mem_q[a1] : '0;
    assign t2 = m2 ? mem_q[a2] : '0;
    assign t3 = m3 ? mem_q[a3] : '0;
    assign d_c = zext(x) - zext(t1) - zext(t2) + zext(t3);

    always_ff @(posedge clk) begin
      if (in_valid) mem_q[wa] <= x;
    end

    assign s_sum = s_q + d_q;
    assign y_sh  = s_sum >>> norm_q;

    always_comb begin
      y_d = y_sh[SIZE_SHAPER_DATA-1:0];
      if (y_sh > Y_MAX)      y_d = Y_MAX[SIZE_SHAPER_DATA-1:0];
      else if (y_sh < Y_MIN) y_d = Y_MIN[SIZE_SHAPER_DATA-1:0];
    end

    // On an accepted load the stage-2 sample still belongs to the old config:
    // it is emitted from the old accumulator while the accumulator clears.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        d_q <= '0;
        s_q <= '0;
        y_q <= '0;
      end else begin
        if (in_valid) d_q <= d_c;
        if (cfg_ok)      s_q <= '0;
        else if (vld1_q) s_q <= s_sum;
        if (vld1_q) y_q <= y_d;
      end
    end

    assign out_data[c*SIZE_SHAPER_DATA +: SIZE_SHAPER_DATA] = y_q;
  end

endmodule

// File: tb/tb_trapez_shaper_mc.sv
// tb_trapez_shaper_mc: directed stimulus for trapez_shaper_mc with a window-sum reference model.
// Latency: outputs expected exactly 2 cycles after each applied sample.
// Backpressure: none; outputs are scored as they appear.
module tb_trapez_shaper_mc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [27:0] in_data;
  logic        cfg_load;
  logic [8:0]  cfg_k;
  logic [8:0]  cfg_l;
  logic [4:0]  cfg_norm;
  logic        cfg_error;
  logic        out_valid;
  logic [31:0] out_data;
  logic        settled;

  trapez_shaper_mc dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .cfg_load (cfg_load),
    .cfg_k    (cfg_k),
    .cfg_l    (cfg_l),
    .cfg_norm (cfg_norm),
    .cfg_error(cfg_error),
    .out_valid(out_valid),
    .out_data (out_data),
    .settled  (settled)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int n;
    int y0;
    int y1;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   kk    = 25;
  int   ll    = 20;
  int   nn    = 10;
  int   ns    = 0;
  int   xh  [2][512];
  int   obs [2][512];

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int xv(int c, int m);
    return (m < 1) ? 0 : xh[c][m];
  endfunction

  // s(n) = sum of the last k samples minus the k samples ending k+l earlier.
  function automatic int ymodel(int c, int n);
    int s;
    int y;
    s = 0;
    for (int i = 0; i < kk; i++) s += xv(c, n - i) - xv(c, n - kk - ll - i);
    y = s >>> nn;
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return y;
  endfunction

  task automatic clear_obs();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 512; i++) obs[c][i] = -99999;
  endtask

  task automatic monitor();
    exp_t             e;
    bit               ev;
    logic signed [15:0] y0;
    logic signed [15:0] y1;
    ev = (q.size() > 0) && (q[0].due == cyc);
    chk("out_valid", out_valid, ev);
    if (ev) begin
      e  = q.pop_front();
      y0 = out_data[15:0];
      y1 = out_data[31:16];
      chk("y_ch0", y0, e.y0);
      chk("y_ch1", y1, e.y1);
      obs[0][e.n] = y0;
      obs[1][e.n] = y1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic apply_sample(input int x0, input int x1);
    exp_t e;
    in_valid = 1'b1;
    in_data  = {x1[13:0], x0[13:0]};
    ns++;
    xh[0][ns] = x0;
    xh[1][ns] = x1;
    e.due = cyc + 2;
    e.n   = ns;
    e.y0  = ymodel(0, ns);
    e.y1  = ymodel(1, ns);
    q.push_back(e);
  endtask

  task automatic sample(input int x0, input int x1);
    apply_sample(x0, x1);
    tick();
    in_valid = 1'b0;
    chk("settled", settled, ns >= 2 * kk + ll);
  endtask

  task automatic cfg(input int k, input int l, input int nm, input bit with_smp, input int x0, input int x1);
    bit ok;
    ok       = (k >= 1) && (2 * k + l <= 300) && (nm <= 24);
    cfg_load = 1'b1;
    cfg_k    = k[8:0];
    cfg_l    = l[8:0];
    cfg_norm = nm[4:0];
    if (ok) begin
      kk = k;
      ll = l;
      nn = nm;
      ns = 0;
      clear_obs();
    end
    if (with_smp) apply_sample(x0, x1);
    tick();
    cfg_load = 1'b0;
    in_valid = 1'b0;
    chk("cfg_error", cfg_error, !ok);
    if (with_smp) chk("settled", settled, ns >= 2 * kk + ll);
    tick();
    chk("cfg_error_pulse", cfg_error, 1'b0);
  endtask

  task automatic do_reset(input int cycles);
    q.delete();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 0);
    chk("rst_settled", settled, 1'b0);
    chk("rst_cfg_error", cfg_error, 1'b0);
    repeat (cycles) tick();
    reset_n = 1'b1;
    kk = 25;
    ll = 20;
    nn = 10;
    ns = 0;
    clear_obs();
  endtask

  task automatic drain();
    repeat (3) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    cfg_load = 1'b0;
    cfg_k    = '0;
    cfg_l    = '0;
    cfg_norm = '0;
    clear_obs();
    #3;
    do_reset(2);

    // Default shape: ch0 step of 1024.
    for (int i = 1; i <= 75; i++) sample(1024, 0);
    drain();
    chk("A_y1", obs[0][1], 1);
    chk("A_y25", obs[0][25], 25);
    chk("A_y45", obs[0][45], 25);
    chk("A_y46", obs[0][46], 24);
    chk("A_y70", obs[0][70], 0);

    // Reload defaults, reject an oversize request mid-stream, shape unchanged.
    cfg(25, 20, 10, 1'b0, 0, 0);
    for (int i = 1; i <= 30; i++) sample(1024, 0);
    cfg(150, 1, 0, 1'b0, 0, 0);
    cfg(0, 5, 3, 1'b0, 0, 0);
    cfg(10, 0, 25, 1'b0, 0, 0);
    for (int i = 31; i <= 75; i++) sample(1024, 0);
    drain();
    chk("D_y25", obs[0][25], 25);
    chk("D_y40", obs[0][40], 25);
    chk("D_y70", obs[0][70], 0);

    // Triangle, l = 0.
    cfg(10, 0, 0, 1'b0, 0, 0);
    for (int i = 1; i <= 25; i++) sample(3, 100);
    drain();
    chk("C_ch1_y5", obs[1][5], 500);
    chk("C_ch1_y10", obs[1][10], 1000);
    chk("C_ch1_y20", obs[1][20], 0);
    chk("C_ch0_y10", obs[0][10], 30);

    // k = 1 with load and sample in the same cycle.
    cfg(1, 0, 0, 1'b1, 16383, 0);
    for (int i = 2; i <= 4; i++) sample(16383, 0);
    drain();
    chk("E_k1_y1", obs[0][1], 16383);
    chk("E_k1_y2", obs[0][2], 0);

    // k = 4: positive then negative saturation.
    cfg(4, 0, 0, 1'b1, 16383, 0);
    for (int i = 2; i <= 10; i++) sample(16383, 0);
    for (int i = 11; i <= 18; i++) sample(0, 0);
    drain();
    chk("E_k4_y2", obs[0][2], 32766);
    chk("E_k4_y3", obs[0][3], 32767);
    chk("E_k4_y11", obs[0][11], -16383);
    chk("E_k4_y13", obs[0][13], -32768);
    chk("E_k4_y17", obs[0][17], -16383);

    // Reset restores defaults; reset again during the flat-top.
    do_reset(2);
    for (int i = 1; i <= 30; i++) sample(1024, 0);
    do_reset(2);
    drain();
    for (int i = 1; i <= 75; i++) sample(1024, 0);
    drain();
    chk("B_y10", obs[0][10], 10);
    chk("B_y25", obs[0][25], 25);
    chk("B_y70", obs[0][70], 0);

    // One sample every third cycle, step on ch0 straddling the pointer wrap.
    do_reset(1);
    for (int i = 1; i <= 360; i++) begin
      sample((i >= 280) ? 1024 : 0, 2048);
      tick();
      tick();
    end
    drain();
    chk("G_ch0_y300", obs[0][300], 21);
    chk("G_ch0_y304", obs[0][304], 25);
    chk("G_ch0_y330", obs[0][330], 19);
    chk("G_ch0_y349", obs[0][349], 0);
    chk("G_ch1_y25", obs[1][25], 50);
    chk("G_ch1_y360", obs[1][360], 0);

    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/trapez_shaper_mc.md
TRAPEZ_SHAPER_MC -- requirements
Module: trapez_shaper_mc

Interface
REQ-001 Parameter CHANNEL_SIZE, default 2: number of independent shaper channels.
REQ-002 Parameter SIZE_ADC_DATA, default 14: unsigned ADC sample width.
REQ-003 Parameter SIZE_SHAPER_DATA, default 16: signed output width.
REQ-004 Parameter SIZE_SHAPER_SHIFT_REG, default 300: delay-line depth MAX_D in samples.
REQ-005 Parameter K_DEFAULT, default 25; L_DEFAULT, default 20; NORM_DEFAULT, default 10: post-reset rise, flat-top and right-shift.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 in_valid  input  1  one sample per channel present this cycle.
REQ-009 in_data  input  CHANNEL_SIZE*SIZE_ADC_DATA  channel c at bits [c*SIZE_ADC_DATA +: SIZE_ADC_DATA].
REQ-010 cfg_load  input  1  single-cycle request to apply cfg_k/cfg_l/cfg_norm.
REQ-011 cfg_k  input  9; cfg_l  input  9; cfg_norm  input  5  requested rise, flat-top, shift.
REQ-012 cfg_error  output  1  one-cycle pulse: request rejected.
REQ-013 out_valid  output  1  out_data valid this cycle.
REQ-014 out_data  output  CHANNEL_SIZE*SIZE_SHAPER_DATA  signed trapezoid per channel, same packing as in_data.
REQ-015 settled  output  1  high when delay lines hold at least 2k+l real samples since last flush.

Function
REQ-016 Per channel: d(n) = x(n) - x(n-k) - x(n-k-l) + x(n-2k-l); s(n) = s(n-1) + d(n); y(n) = sat(s(n) >>> norm), arithmetic shift, saturated to signed SIZE_SHAPER_DATA.
REQ-017 x zero-extended to signed; accumulator width SIZE_ADC_DATA + clog2(MAX_D) + 2; no internal wrap-around of s.
REQ-018 Delay line: per-channel circular buffer depth MAX_D+1, shared write pointer advancing only on in_valid, wrapping MAX_D -> 0; tap address = (wr_ptr - D) modulo (MAX_D+1).
REQ-019 Latency: out_valid asserted exactly 2 cycles after each in_valid cycle; no other cycle asserts out_valid; no backpressure.
REQ-020 States: FILL and RUN. FILL: fill counter counts in_valid samples, saturating at 2k+l; a tap at delay D returns 0 while fill < D. FILL -> RUN when fill reaches 2k+l; settled = (state == RUN).
REQ-021 cfg_load accepted when 1 <= cfg_k, 2*cfg_k + cfg_l <= MAX_D, cfg_norm <= 24: latch k/l/norm, clear accumulators, fill counter, wr_ptr; enter FILL; in-flight pipeline outputs of the previous config are still emitted.
REQ-022 cfg_load rejected otherwise: cfg_error high for exactly the next cycle; configuration, state and data path unchanged.
REQ-023 cfg_load and in_valid in the same cycle: sample is the first sample under the new configuration (fill = 1 after it).
REQ-024 l = 0 SHALL produce a triangle; k + l taps coinciding is legal and summed independently.
REQ-025 Saturation: s >>> norm above max -> 2^(SIZE_SHAPER_DATA-1)-1; below min -> -2^(SIZE_SHAPER_DATA-1).

Reset
REQ-026 reset_n low: k/l/norm = defaults, state FILL, fill = 0, wr_ptr = 0, accumulators 0, out_valid 0, out_data 0, cfg_error 0, settled 0; pipeline contents discarded.
REQ-027 Reset asserted mid-stream aborts all in-flight samples; no out_valid until 2 cycles after first in_valid following release.
REQ-028 Buffer RAM contents need no reset; masking per REQ-020 guarantees zero history.

Verification
REQ-029 Defaults, ch0 step 0 -> 1024 held, in_valid every cycle -> y ramps 1,2,...,25 over 25 samples, flat 25 for 20 samples, ramps down to 0 after 70 samples total; settled rises after sample 70.
REQ-030 cfg_load k=10, l=0, norm=0, ch1 step of 100 -> triangle peak 1000 at sample 10, 0 at sample 20; ch0 unaffected.
REQ-031 cfg_load k=150, l=1 (2k+l=301 > 300) -> cfg_error one cycle, subsequent step still yields default shape.
REQ-032 k=1, l=0, norm=0, input 16383 step, SIZE_SHAPER_DATA=16 -> output 16383 for one sample; with k=4, output saturates at 32767.
REQ-033 in_valid gapped (1 of 3 cycles) across a wr_ptr wrap (>301 samples) -> output sequence identical to gapless run, each 2 cycles after its input.
REQ-034 reset_n pulsed low during flat-top -> all outputs 0, out_valid 0, defaults restored, next step reproduces REQ-029.
